// File: rtl/cordic_vec_pkg.sv
// Shared CORDIC definitions: Q2.14 constants, FSM encoding and the arctangent table.
// Used by both the rotation-mode and vectoring-mode units.
package cordic_vec_pkg;

    localparam int          Q_FRAC    = 14;
    localparam int          ITR_DEF   = 16;
    localparam string       ATAN_FILE = "cordic_atan.txt";
    localparam logic [15:0] HALF_PI   = 16'h6488;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // atan(2^-i) in Q2.14 radians; same contents as the ROM init file
    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'd12868;
            4'd1:    atan_lut = 16'd7596;
            4'd2:    atan_lut = 16'd4014;
            4'd3:    atan_lut = 16'd2037;
            4'd4:    atan_lut = 16'd1023;
            4'd5:    atan_lut = 16'd512;
            4'd6:    atan_lut = 16'd256;
            4'd7:    atan_lut = 16'd128;
            4'd8:    atan_lut = 16'd64;
            4'd9:    atan_lut = 16'd32;
            4'd10:   atan_lut = 16'd16;
            4'd11:   atan_lut = 16'd8;
            4'd12:   atan_lut = 16'd4;
            4'd13:   atan_lut = 16'd2;
            4'd14:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_ctrl.sv
// Sequencer for the vectoring CORDIC: IDLE -> INIT -> ITER -> DONE, with the
// iteration counter and the bgn/fin handshake.
module cordic_vec_ctrl
    import cordic_vec_pkg::*;
#(
    parameter int ITR = ITR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bgn,
    output logic       cap,
    output logic       ld,
    output logic       init,
    output logic       last,
    output logic [3:0] cnt,
    output logic       busy,
    output logic       fin
);

    localparam logic [3:0] LAST_I = 4'(ITR - 1);

    state_t state;

    assign cap  = (state == IDLE) && bgn;
    assign init = (state == INIT);
    assign ld   = (state == INIT) || (state == ITER);
    assign last = (state == ITER) && (cnt == LAST_I);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            fin   <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: if (bgn) begin
                    state <= INIT;
                    busy  <= 1'b1;
                end
                INIT: state <= ITER;
                ITER: if (cnt == LAST_I) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    fin   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 4'd0;
        else if (init)
            cnt <= 4'd0;
        else if (ld)
            cnt <= cnt + 4'd1;
    end

endmodule

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: drives y to zero to produce atan2(y, x)
// and the uncompensated (gain ~1.6468) magnitude of a Q2.14 vector.
module cordic_vec
    import cordic_vec_pkg::*;
#(
    parameter int W   = 16,
    parameter int ITR = ITR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bgn,
    input  logic [W-1:0]   x_in,
    input  logic [W-1:0]   y_in,
    output logic [W:0]     angle,
    output logic [W+1:0]   mag,
    output logic           busy,
    output logic           fin
);

    localparam int XW = W + 3;
    localparam int ZW = W + 1;
    localparam logic signed [ZW-1:0] HP = ZW'(HALF_PI);

    logic           cap, ld, init, last;
    logic [3:0]     cnt;
    logic           zero_in;

    logic signed [W-1:0]  x_l, y_l;
    logic signed [XW-1:0] x, y, xe, ye, xi, yi, x_sh, y_sh, x_nx, y_nx;
    logic signed [ZW-1:0] z, zi, z_nx, at;

    cordic_vec_ctrl #(.ITR(ITR)) u_ctrl (
        .clk  (clk),
        .rst  (rst),
        .bgn  (bgn),
        .cap  (cap),
        .ld   (ld),
        .init (init),
        .last (last),
        .cnt  (cnt),
        .busy (busy),
        .fin  (fin)
    );

    // Sign-extend before negating so -0x8000 does not wrap
    assign xe = {{(XW-W){x_l[W-1]}}, x_l};
    assign ye = {{(XW-W){y_l[W-1]}}, y_l};

    always_comb begin
        xi = xe;
        yi = ye;
        zi = '0;
        if (x_l[W-1]) begin
            if (!y_l[W-1]) begin
                xi = ye;
                yi = -xe;
                zi = HP;
            end else begin
                xi = -ye;
                yi = xe;
                zi = -HP;
            end
        end
    end

    assign x_sh = x >>> cnt;
    assign y_sh = y >>> cnt;
    assign at   = {{(ZW-16){1'b0}}, atan_lut(cnt)};

    always_comb begin
        if (!y[XW-1]) begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + at;
        end else begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - at;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_l     <= '0;
            y_l     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            zero_in <= 1'b0;
            angle   <= '0;
            mag     <= '0;
        end else begin
            if (cap) begin
                x_l <= x_in;
                y_l <= y_in;
            end
            if (init) begin
                x       <= xi;
                y       <= yi;
                z       <= zi;
                zero_in <= (x_l == '0) && (y_l == '0);
            end else if (ld) begin
                x <= x_nx;
                y <= y_nx;
                z <= z_nx;
            end
            // A zero vector never leaves the y>=0 branch, so z would collect the whole table
            if (last) begin
                angle <= zero_in ? '0 : z_nx;
                mag   <= x_nx[W+1:0];
            end
        end
    end

endmodule

// File: doc/cordic_vec.md
Name: cordic_vec

Overview:
- Iterative CORDIC in vectoring mode; the inverse direction of the existing rotation-mode cosine unit.
- Takes a signed Q2.14 vector (x, y) and drives y to zero to produce the angle atan2(y, x) and the CORDIC-gained magnitude.
- Reuses the same Q2.14 arctangent table ROM, the register primitive and the counter primitive already in the codebase.
- Sits beside the rotation unit in the CA datapath and uses the same bgn/fin handshake.

Parameters:
- W, 16: input data width; inputs are signed Q2.14 (1.0 = 0x4000).
- ITR, 16: number of micro-rotations; range 1..16, because the iteration index is 4 bits.
- ATAN_FILE, "cordic_atan.txt": ROM init file; entry i = atan(2^-i) in Q2.14 radians.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- bgn  in  1  start request, sampled only in IDLE.
- x_in  in  W  signed Q2.14 x, sampled on the start edge.
- y_in  in  W  signed Q2.14 y, sampled on the start edge.
- angle  out  W+1  signed Q3.14 radians, range [-pi, +pi].
- mag  out  W+2  unsigned Q4.14, approximately 1.6468*sqrt(x^2+y^2); gain is not compensated.
- busy  out  1  high from the cycle after bgn is accepted until fin.
- fin  out  1  one-cycle pulse; angle and mag are valid from this cycle.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; x, y, z, the counter, angle, mag, busy and fin all become 0.
- Reset mid-operation aborts the computation; no fin is produced.
- FSM states: IDLE -> INIT -> ITER -> DONE -> IDLE.
- IDLE:
  - bgn=1 at a rising edge captures x_in/y_in into input latches and moves to INIT.
  - bgn is ignored in every other state.
- INIT (1 cycle): load x, y, z (x, y are W+3 bits signed; z is W+1 bits signed), sign-extended, with quadrant preconvergence:
  - x_in >= 0: x = x_in, y = y_in, z = 0.
  - x_in < 0, y_in >= 0: x = y_in, y = -x_in, z = +HALF_PI (0x6488).
  - x_in < 0, y_in < 0: x = -y_in, y = x_in, z = -HALF_PI.
  - Iteration counter is cleared to 0.
- ITER: ITR cycles, iteration i = counter value. On each edge:
  - If y >= 0: x += y>>>i; y -= x>>>i; z += atan[i].
  - Else: x -= y>>>i; y += x>>>i; z -= atan[i].
  - >>> is an arithmetic right shift with truncation. Both updates use the pre-edge x and y.
  - atan[i] is sign-extended to W+1 bits.
  - Counter increments each edge; leave ITER on the edge that applies i = ITR-1.
- Arithmetic width rules:
  - W+3 bits gives |x|, |y| headroom to about 4.66 for all legal inputs; no overflow or saturation is required.
  - z never exceeds +/-(pi + atan[0]) and fits in W+1 bits.
- DONE (1 cycle):
  - fin = 1, busy = 0.
  - angle <= z; mag <= x[W+1:0], which is always >= 0 after preconvergence.
  - angle and mag hold until the next DONE or reset.
- Latency: with bgn sampled at edge 0, fin is high in the cycle after edge ITR+1 (edge 17 for the default).
- Back-to-back: bgn high during the DONE cycle is ignored; it is accepted the next cycle in IDLE.
- Boundary cases:
  - x=y=0: angle=0, mag=0.
  - x<0, y=0: takes the y>=0 branch, so the result is +pi, never -pi.
  - Extreme input -0x8000 is legal; negation happens after sign-extension, so it does not wrap.

Decomposition:
- Shared package: HALF_PI=0x6488, the default ITR, the ATAN_FILE name, the Q-format widths, and the FSM state encoding (2 bits).
- The same package is shared with the rotation-mode unit.
- Sub-module cordic_vec_ctrl:
  - FSM, generating ld, init, busy and fin.
  - The counter is the existing counter primitive, with clr=init and c_up=ld & ~init.
- The datapath uses the existing register primitive and the existing ROM (aw=4, dw=16).

Test Plan:
- x_in=0x4000, y_in=0: fin after 17 edges; angle=0 within ±4 LSB; mag=0x6965 (26981) within ±6 LSB.
- x_in=0, y_in=0x4000: angle=0x06488 within ±4; mag≈26981. Also x_in=0, y_in=-0x4000: angle=-0x6488 (0x19B78) within ±4.
- x_in=y_in=0x2D41: angle=0x3244 (pi/4) within ±4, mag≈26981. Also x_in=-0x4000, y_in=0: angle=+51472 (0x0C910) within ±4.
- x_in=y_in=0: angle=0, mag=0. Also x_in=y_in=-0x8000: angle≈-3pi/4 (-38604) within ±6, with no overflow.
- bgn pulsed again at cycles 5 and 17 of a run: ignored, exactly one fin; busy is high for 17 cycles.
- Assert rst at iteration 8: outputs immediately 0 and FSM in IDLE; a new bgn afterwards gives a correct result.
